core_reg_file_sb: RTL and testbench

Parametrised integer register file for the Selen core, successor to the fixed 32x32 register file. It provides two registered read ports with an operand-swap control, one write port and a per-register busy scoreboard, so decode can detect RAW hazards against in-flight writes. It sits between decode, which reads and allocates, and writeback, which writes and clears busy bits.

---
 rtl/core_reg_file_sb.sv | 117 +++++++++++
 tb/tb_core_reg_file_sb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_reg_file_sb.sv
// core_reg_file_sb: NREGS x XLEN integer register file with swapped read pair,
// one write port and busy scoreboard. Optional macro: CORE_RF_BYPASS_EN.
module core_reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic             order,
  output logic [XLEN-1:0]  src1_out_r,
  output logic [XLEN-1:0]  src2_out_r,
  output logic             src1_busy_r,
  output logic             src2_busy_r,
  input  logic             we,
  input  logic [AW-1:0]    rd,
  input  logic [XLEN-1:0]  data_in,
  input  logic             alloc_en,
  input  logic [AW-1:0]    alloc_rd,
  output logic [NREGS-1:0] busy_vec
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]  src1_q, src1_d;
  logic [XLEN-1:0]  src2_q, src2_d;
  logic             sb1_q, sb1_d;
  logic             sb2_q, sb2_d;

  logic            wr_hit, al_hit;
  logic [AW-1:0]   sel1, sel2;
  logic [XLEN-1:0] rv1, rv2;
  logic            rb1, rb2;

  always_comb begin
    wr_hit = we && (rd != '0);
    al_hit = alloc_en && (alloc_rd != '0);
    sel1   = order ? rs2 : rs1;
    sel2   = order ? rs1 : rs2;
  end

  always_comb begin
    rv1 = regs_q[sel1];
    rb1 = busy_q[sel1];
    rv2 = regs_q[sel2];
    rb2 = busy_q[sel2];
`ifdef CORE_RF_BYPASS_EN
    // forward the in-flight write; a same-cycle alloc keeps it pending
    if (wr_hit && (sel1 == rd)) begin
      rv1 = data_in;
      rb1 = al_hit && (alloc_rd == rd);
    end
    if (wr_hit && (sel2 == rd)) begin
      rv2 = data_in;
      rb2 = al_hit && (alloc_rd == rd);
    end
`endif
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_hit) begin
      regs_d[rd] = data_in;
      busy_d[rd] = 1'b0;
    end
    if (al_hit) begin
      busy_d[alloc_rd] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    src1_d = src1_q;
    src2_d = src2_q;
    sb1_d  = sb1_q;
    sb2_d  = sb2_q;
    if (rd_en) begin
      src1_d = rv1;
      src2_d = rv2;
      sb1_d  = rb1;
      sb2_d  = rb2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
      sb1_q  <= 1'b0;
      sb2_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
      sb1_q  <= sb1_d;
      sb2_q  <= sb2_d;
    end
  end

  assign src1_out_r  = src1_q;
  assign src2_out_r  = src2_q;
  assign src1_busy_r = sb1_q;
  assign src2_busy_r = sb2_q;
  assign busy_vec    = busy_q;

endmodule

// File: tb/tb_core_reg_file_sb.sv
// Bench for core_reg_file_sb: array/scoreboard model checked every cycle,
// directed vectors with literal pins, plus a 64x16 width instance.
module tb_core_reg_file_sb;

`ifdef CORE_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en, order, we, alloc_en;
  logic [4:0]  rs1, rs2, rd, alloc_rd;
  logic [31:0] data_in;
  logic [31:0] src1_out_r, src2_out_r;
  logic        src1_busy_r, src2_busy_r;
  logic [31:0] busy_vec;

  logic        w_rd_en, w_order, w_we, w_alloc_en;
  logic [3:0]  w_rs1, w_rs2, w_rd, w_alloc_rd;
  logic [63:0] w_data_in, w_src1, w_src2;
  logic        w_b1, w_b2;
  logic [15:0] w_busy_vec;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  core_reg_file_sb dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rs1(rs1), .rs2(rs2),
    .order(order), .src1_out_r(src1_out_r), .src2_out_r(src2_out_r),
    .src1_busy_r(src1_busy_r), .src2_busy_r(src2_busy_r), .we(we),
    .rd(rd), .data_in(data_in), .alloc_en(alloc_en),
    .alloc_rd(alloc_rd), .busy_vec(busy_vec)
  );

  core_reg_file_sb #(.XLEN(64), .NREGS(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .rd_en(w_rd_en), .rs1(w_rs1), .rs2(w_rs2),
    .order(w_order), .src1_out_r(w_src1), .src2_out_r(w_src2),
    .src1_busy_r(w_b1), .src2_busy_r(w_b2), .we(w_we), .rd(w_rd),
    .data_in(w_data_in), .alloc_en(w_alloc_en),
    .alloc_rd(w_alloc_rd), .busy_vec(w_busy_vec)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural register values and pending flags.
  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  logic [31:0] e_s1, e_s2;
  bit          e_b1, e_b2;

  function automatic logic [31:0] m_val(input int r);
    if (BYP && we && rd == 5'(r) && r != 0) return data_in;
    return m_reg[r];
  endfunction

  function automatic bit m_bsy(input int r);
    if (BYP && we && rd == 5'(r) && r != 0)
      return alloc_en && alloc_rd == 5'(r);
    return m_busy[r];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
      e_s1 = '0; e_s2 = '0; e_b1 = 0; e_b2 = 0;
    end else begin
      int a, b;
      a = order ? int'(rs2) : int'(rs1);
      b = order ? int'(rs1) : int'(rs2);
      if (rd_en) begin
        e_s1 = m_val(a); e_b1 = m_bsy(a);
        e_s2 = m_val(b); e_b2 = m_bsy(b);
      end
      if (we && rd != 0) begin
        m_reg[rd]  = data_in;
        m_busy[rd] = 1'b0;
      end
      if (alloc_en && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] ev;
      for (int i = 0; i < 32; i++) ev[i] = m_busy[i];
      chk("m_src1", src1_out_r, e_s1);
      chk("m_src2", src2_out_r, e_s2);
      chk("m_busy1", src1_busy_r, e_b1);
      chk("m_busy2", src2_busy_r, e_b2);
      chk("m_busy_vec", busy_vec, ev);
    end
  end

  task automatic st(input bit w, input int r, input logic [31:0] d,
                    input bit a, input int ar, input bit re,
                    input int s1, input int s2, input bit o);
    we = w; rd = 5'(r); data_in = d;
    alloc_en = a; alloc_rd = 5'(ar);
    rd_en = re; rs1 = 5'(s1); rs2 = 5'(s2); order = o;
    @(negedge clk);
    we = 0; alloc_en = 0; rd_en = 0;
  endtask

  initial begin
    rst_n = 0;
    we = 0; rd = 0; data_in = 0; alloc_en = 0; alloc_rd = 0;
    rd_en = 0; rs1 = 0; rs2 = 0; order = 0;
    w_we = 0; w_rd = 0; w_data_in = 0; w_alloc_en = 0; w_alloc_rd = 0;
    w_rd_en = 0; w_rs1 = 0; w_rs2 = 0; w_order = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk_en = 1;

    // reset mid-operation
    st(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    st(0, 0, 0, 1, 9, 1, 5, 9, 0);
    chk("pre_rst_src1", src1_out_r, 32'hDEADBEEF);
    chk("pre_rst_busy2", src2_busy_r, 1'b0);
    chk("pre_rst_bv9", busy_vec[9], 1'b1);
    #2 rst_n = 0;
    #1;
    chk("rst_src1", src1_out_r, 32'h0);
    chk("rst_busy_vec", busy_vec, 32'h0);
    #1 rst_n = 1;
    @(negedge clk);
    st(0, 0, 0, 0, 0, 1, 5, 5, 0);
    chk("rst_r5", src1_out_r, 32'h0);

    // x0 hardwired
    st(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0);
    st(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("x0_val", src1_out_r, 32'h0);
    chk("x0_busy", src1_busy_r, 1'b0);
    chk("x0_bv0", busy_vec[0], 1'b0);

    // swap and hold
    st(1, 1, 32'h11, 0, 0, 0, 0, 0, 0);
    st(1, 2, 32'h22, 0, 0, 0, 0, 0, 0);
    st(0, 0, 0, 0, 0, 1, 1, 2, 1);
    chk("swap1_src1", src1_out_r, 32'h22);
    chk("swap1_src2", src2_out_r, 32'h11);
    st(0, 0, 0, 0, 0, 1, 1, 2, 0);
    chk("swap0_src1", src1_out_r, 32'h11);
    chk("swap0_src2", src2_out_r, 32'h22);
    st(0, 0, 0, 0, 0, 0, 5, 0, 1);
    chk("hold_src1", src1_out_r, 32'h11);
    chk("hold_src2", src2_out_r, 32'h22);
    st(0, 0, 0, 0, 0, 1, 2, 2, 0);
    chk("same_idx", src2_out_r, 32'h22);

    // scoreboard
    st(0, 0, 0, 1, 7, 0, 0, 0, 0);
    chk("sb_alloc_bv7", busy_vec[7], 1'b1);
    st(0, 0, 0, 0, 0, 1, 7, 1, 0);
    chk("sb_read_busy", src1_busy_r, 1'b1);
    st(1, 7, 32'h77, 1, 7, 0, 0, 0, 0);
    chk("sb_wr_alloc_bv7", busy_vec[7], 1'b1);
    st(1, 7, 32'h78, 0, 0, 0, 0, 0, 0);
    chk("sb_wr_bv7", busy_vec[7], 1'b0);
    st(0, 0, 0, 0, 0, 1, 7, 7, 0);
    chk("sb_rd_val", src1_out_r, 32'h78);
    chk("sb_rd_busy", src1_busy_r, 1'b0);
    st(0, 0, 0, 1, 8, 0, 0, 0, 0);
    st(0, 0, 0, 1, 8, 0, 0, 0, 0);
    chk("waw_bv8", busy_vec[8], 1'b1);
    st(1, 8, 32'h88, 0, 0, 0, 0, 0, 0);
    chk("waw_clr_bv8", busy_vec[8], 1'b0);

    // same-cycle write/read
    st(1, 3, 32'h1, 0, 0, 0, 0, 0, 0);
    st(1, 3, 32'h3, 0, 0, 1, 3, 0, 0);
    chk("byp_val", src1_out_r, BYP ? 32'h3 : 32'h1);
    chk("byp_busy", src1_busy_r, 1'b0);
    st(0, 0, 0, 0, 0, 1, 3, 0, 0);
    chk("byp_next", src1_out_r, 32'h3);
    st(1, 4, 32'h4, 1, 4, 1, 0, 4, 0);
    chk("byp_al_val", src2_out_r, BYP ? 32'h4 : 32'h0);
    chk("byp_al_busy", src2_busy_r, BYP);
    chk("byp_al_bv4", busy_vec[4], 1'b1);

    // sweep all indices
    for (int i = 1; i < 32; i++) st(1, i, 32'h01010101 * i, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) st(0, 0, 0, 0, 0, 1, i, 31 - i, i[0]);
    st(0, 0, 0, 0, 0, 1, 10, 21, 0);
    chk("sweep_r10", src1_out_r, 32'h0A0A0A0A);
    chk("sweep_r21", src2_out_r, 32'h15151515);

    // 64-bit, 16-register instance
    w_we = 1; w_rd = 4'd15; w_data_in = 64'h0123456789ABCDEF;
    w_alloc_en = 1; w_alloc_rd = 4'd15;
    @(negedge clk);
    w_we = 0; w_alloc_en = 0;
    chk("w_bv", w_busy_vec, 16'h8000);
    w_rd_en = 1; w_rs1 = 4'd0; w_rs2 = 4'd15; w_order = 1;
    @(negedge clk);
    w_rd_en = 0;
    chk("w_src1", w_src1, 64'h0123456789ABCDEF);
    chk("w_busy1", w_b1, 1'b1);
    chk("w_src2", w_src2, 64'h0);
    w_we = 1; w_rd = 4'd15; w_data_in = 64'hFEDCBA9876543210;
    @(negedge clk);
    w_we = 0;
    chk("w_bv_clr", w_busy_vec, 16'h0000);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
